pwm_pattern_gen: RTL and testbench

Multi-channel PWM pattern generator, parametrised in counter resolution, pattern index depth and channel count.
- A free-running PWM counter feeds a prescaled pattern index. Each channel maps that index to a duty cycle through its own per-channel mode: square, ramp, triangle or off.
- Duty values are latched only at PWM period boundaries, so pulses are glitch-free.
- Sits between the switch/mode control logic and the LED/actuator output pins.

---
 rtl/pwm_pkg.sv | 44 ++++
 rtl/pwm_channel.sv | 39 +++
 rtl/pwm_pattern_gen.sv | 64 ++++++
 tb/tb_pwm_pattern_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and duty-cycle mapping for the PWM pattern generator.
// Purely combinational helpers; no timing or flow control lives here.
package pwm_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'b00,
        MODE_RAMP   = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    // Widest index/counter the mapping function supports.
    localparam int MAX_W = 16;

    // Maps a pattern index to a CNT_W-bit duty, returned right-aligned in MAX_W bits.
    function automatic logic [MAX_W-1:0] duty_map(
        input logic [MAX_W-1:0] idx,
        input int               idx_w,
        input int               cnt_w,
        input mode_e            mode
    );
        logic [MAX_W-1:0] idx_mask;
        logic [MAX_W-1:0] half_mask;
        logic [MAX_W-1:0] cnt_mask;
        logic [MAX_W-1:0] tri_t;
        logic [MAX_W-1:0] res;
        logic             msb;
        idx_mask  = (MAX_W'(1) << idx_w) - MAX_W'(1);
        half_mask = idx_mask >> 1;
        cnt_mask  = (MAX_W'(1) << cnt_w) - MAX_W'(1);
        msb       = |(idx & (MAX_W'(1) << (idx_w - 1)));
        // Falling half of the triangle mirrors the rising half.
        tri_t     = msb ? (~idx & half_mask) : (idx & half_mask);
        res       = '0;
        case (mode)
            MODE_SQUARE: res = msb ? '0 : cnt_mask;
            MODE_RAMP:   res = (idx & idx_mask) >> (idx_w - cnt_w);
            MODE_TRI:    res = (tri_t << 1) >> (idx_w - cnt_w);
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty latched at the period wrap, compared against the shared counter.
// Pulse is registered, 1 cycle behind the count it reflects; no backpressure.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int IDX_W = 6
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             wrap,
    input  logic [CNT_W-1:0] count,
    input  logic [IDX_W-1:0] index,
    input  logic [1:0]       mode,
    input  logic             enable,
    output logic             pulse
);

    logic [CNT_W-1:0] duty_d;
    logic [CNT_W-1:0] duty_q;

    always_comb begin
        duty_d = CNT_W'(duty_map(MAX_W'(index), IDX_W, CNT_W, mode_e'(mode)));
    end

    // Duty only changes on the wrap edge so no pulse is ever truncated mid-period.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pulse  <= 1'b0;
        end else begin
            if (wrap) begin
                duty_q <= duty_d;
            end
            pulse <= enable && (count < duty_q);
        end
    end

endmodule

// File: rtl/pwm_pattern_gen.sv
// Multi-channel PWM pattern generator: free-running counter, prescaled pattern index, per-channel duty.
// Outputs registered (1-cycle latency); free-running, no backpressure.
module pwm_pattern_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int IDX_W = 6,
    parameter int CH    = 4,
    parameter int PRE_W = 4
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [CH-1:0]     enable,
    input  logic [2*CH-1:0]   mode,
    input  logic [PRE_W-1:0]  prescale,
    output logic [CH-1:0]     pulse,
    output logic              period_tick,
    output logic [IDX_W-1:0]  index
);

    logic [CNT_W-1:0] count;
    logic [PRE_W-1:0] pre_cnt;
    logic             wrap;

    assign wrap = &count;

    // >= rather than == so lowering prescale mid-step cannot strand pre_cnt above it.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            pre_cnt     <= '0;
            index       <= '0;
            period_tick <= 1'b0;
        end else begin
            count       <= count + 1'b1;
            period_tick <= wrap;
            if (wrap) begin
                if (pre_cnt >= prescale) begin
                    pre_cnt <= '0;
                    index   <= index + 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W),
            .IDX_W (IDX_W)
        ) u_ch (
            .sysclk (sysclk),
            .rst_n  (rst_n),
            .wrap   (wrap),
            .count  (count),
            .index  (index),
            .mode   (mode[2*c +: 2]),
            .enable (enable[c]),
            .pulse  (pulse[c])
        );
    end

endmodule

// File: tb/tb_pwm_pattern_gen.sv
// Directed bench for pwm_pattern_gen: per-period high-time tables plus enable/prescale/reset sequences.
module tb_pwm_pattern_gen;
    import pwm_pkg::*;

    localparam int CNT_W = 6;
    localparam int IDX_W = 6;
    localparam int CH    = 4;
    localparam int PRE_W = 4;
    localparam int PER   = 1 << CNT_W;

    logic              sysclk;
    logic              rst_n;
    logic [CH-1:0]     enable;
    logic [2*CH-1:0]   mode;
    logic [PRE_W-1:0]  prescale;
    logic [CH-1:0]     pulse;
    logic              period_tick;
    logic [IDX_W-1:0]  index;

    pwm_pattern_gen #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W),
        .CH    (CH),
        .PRE_W (PRE_W)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .prescale    (prescale),
        .pulse       (pulse),
        .period_tick (period_tick),
        .index       (index)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // ch0 square, ch1 ramp, ch2 triangle, ch3 off
    localparam logic [2*CH-1:0] M_DEF = {MODE_OFF, MODE_TRI, MODE_RAMP, MODE_SQUARE};
    localparam logic [2*CH-1:0] M_CHG = {MODE_SQUARE, MODE_TRI, MODE_RAMP, MODE_SQUARE};

    typedef struct {
        int p;
        int rp;
        int tr;
        int idx;
    } vec_t;

    vec_t tv [7];
    int   pidx [11];
    int   hi [CH];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge where a period begins; samples the 2^CNT_W pulses of that period.
    task automatic run_period(input int mid_k, input logic [2*CH-1:0] mid_mode, input string tag);
        int ticks;
        ticks = 0;
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int k = 1; k <= PER; k++) begin
            @(negedge sysclk);
            for (int c = 0; c < CH; c++) if (pulse[c]) hi[c]++;
            if (period_tick) ticks++;
            if (k == mid_k) mode = mid_mode;
        end
        check({tag, "_tick"}, (ticks == 1 && period_tick) ? 1 : 0, 1);
    endtask

    task automatic do_reset(input logic [PRE_W-1:0] pre);
        @(negedge sysclk);
        rst_n    = 1'b0;
        prescale = pre;
        mode     = M_DEF;
        enable   = '1;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    initial begin
        int vi;
        int start_idx;
        int mism;
        int exp_p;

        tv[0] = '{0, 0, 0, 0};
        tv[1] = '{1, 0, 0, 1};
        tv[2] = '{2, 1, 2, 2};
        tv[3] = '{32, 31, 62, 32};
        tv[4] = '{33, 32, 62, 33};
        tv[5] = '{64, 63, 0, 0};
        tv[6] = '{65, 0, 0, 1};
        pidx  = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3};

        rst_n    = 1'b0;
        enable   = '1;
        mode     = M_DEF;
        prescale = '0;
        repeat (2) @(negedge sysclk);
        check("rst_pulse", int'(pulse), 0);
        check("rst_index", int'(index), 0);
        check("rst_tick", int'(period_tick), 0);
        rst_n = 1'b1;

        // Full pattern with prescale 0: square/ramp/triangle/off side by side.
        vi = 0;
        for (int p = 0; p <= 65; p++) begin
            start_idx = int'(index);
            run_period(-1, M_DEF, $sformatf("pat_p%0d", p));
            check($sformatf("sq_p%0d", p), hi[0], ((p >= 1 && p <= 32) || p == 65) ? 63 : 0);
            check($sformatf("off_p%0d", p), hi[3], 0);
            if (vi < 7 && tv[vi].p == p) begin
                check($sformatf("ramp_p%0d", p), hi[1], tv[vi].rp);
                check($sformatf("tri_p%0d", p), hi[2], tv[vi].tr);
                check($sformatf("idx_p%0d", p), start_idx, tv[vi].idx);
                vi++;
            end
        end

        // Asynchronous reset in the middle of a square high phase.
        repeat (10) @(negedge sysclk);
        check("pre_rst_pulse0", int'(pulse[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pulse", int'(pulse), 0);
        check("async_index", int'(index), 0);
        check("async_tick", int'(period_tick), 0);
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        run_period(-1, M_DEF, "rr_p0");
        check("rr_p0_sq", hi[0], 0);
        run_period(-1, M_DEF, "rr_p1");
        check("rr_p1_sq", hi[0], 63);
        for (int p = 2; p <= 40; p++) run_period(-1, M_DEF, $sformatf("rr_p%0d", p));

        // Period 41: ramp duty 40 on ch1, enable[1] dropped at count 10 and restored at 20.
        check("en_idx_start", int'(index), 41);
        mism = 0;
        for (int k = 1; k <= PER; k++) begin
            @(negedge sysclk);
            exp_p = ((k - 1) < 40 && !(k >= 11 && k <= 20)) ? 1 : 0;
            if (int'(pulse[1]) != exp_p) mism++;
            if (k == 11) check("en_off_next", int'(pulse[1]), 0);
            if (k == 21) check("en_on_next", int'(pulse[1]), 1);
            if (k == 40) check("en_last_high", int'(pulse[1]), 1);
            if (k == 41) check("en_after_duty", int'(pulse[1]), 0);
            if (k == 10) enable[1] = 1'b0;
            if (k == 20) enable[1] = 1'b1;
        end
        check("en_seq_mism", mism, 0);
        check("en_idx_end", int'(index), 42);

        // Prescale 7 lowered to 1 once pre_cnt reaches 5; mode change mid-period on ch3.
        do_reset(PRE_W'(7));
        for (int p = 0; p <= 10; p++) begin
            check($sformatf("ps_idx_p%0d", p), int'(index), pidx[p]);
            if (p == 5) prescale = PRE_W'(1);
            run_period((p == 8) ? 30 : -1, M_CHG, $sformatf("ps_p%0d", p));
            if (p == 8) check("mode_mid_p8", hi[3], 0);
            if (p == 9) begin
                check("mode_new_p9", hi[3], 63);
                check("ps_tri_p9", hi[2], 4);
                check("ps_ramp_p9", hi[1], 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
